// File: rtl/alu_stream_pkg.sv
// Shared types for the stream ALU: opcodes, flag layout and skid-buffer occupancy.
package alu_stream_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_ADDS = 3'b101,
    OP_SUBS = 3'b110,
    OP_ILL  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic err;
    logic sat;
    logic zero;
    logic ovf;
    logic carry;
  } alu_flags_t;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_SAT   = 3;
  localparam int FLAG_ERR   = 4;
  localparam int FLAGS_W    = 5;

  // Number of results held: output register only, or output register plus skid.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: registered output slot plus one overflow slot, FIFO order.
module stream_skid_buf
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output skid_state_e      state
);

  skid_state_e      next_state;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             pop;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = out_q;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= SKID_EMPTY;
    else     state <= next_state;
  end

  // in_valid is a push; the caller never pushes while SKID_TWO is held.
  always_comb begin
    next_state    = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (in_valid) begin
          next_state   = SKID_ONE;
          load_out_new = 1'b1;
        end
      end
      SKID_ONE: begin
        case ({in_valid, pop})
          2'b11:   load_out_new = 1'b1;
          2'b10: begin
            next_state = SKID_TWO;
            load_skid  = 1'b1;
          end
          2'b01:   next_state = SKID_EMPTY;
          default: next_state = SKID_ONE;
        endcase
      end
      SKID_TWO: begin
        if (pop) begin
          load_out_skid = 1'b1;
          if (in_valid) load_skid  = 1'b1;
          else          next_state = SKID_ONE;
        end
      end
      default: next_state = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_new)       out_q <= in_data;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_stream.sv
// Registered two-operand stream ALU: joins A (with opcode) and B, emits {flags, result}.
module alu_stream
  import alu_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_a_i,
  input  logic [2:0]            in_a_op_i,
  input  logic                  in_a_valid_i,
  output logic                  in_a_ready_o,
  input  logic [DATA_WIDTH-1:0] in_b_i,
  input  logic                  in_b_valid_i,
  output logic                  in_b_ready_o,
  output logic [DATA_WIDTH-1:0] out_o,
  output logic [4:0]            out_flags_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int PW  = FLAGS_W + DATA_WIDTH;
  localparam int MSB = DATA_WIDTH - 1;

  skid_state_e   skid_state;
  logic          full;
  logic          fire;
  logic [PW-1:0] alu_payload;
  logic [PW-1:0] out_payload;

  function automatic logic [PW-1:0] alu_eval(input alu_op_e op,
                                             input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] res;
    alu_flags_t            f;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = '0;
    f    = '0;
    case (op)
      OP_ADD: begin
        res     = sum[MSB:0];
        f.carry = sum[DATA_WIDTH];
        f.ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res     = diff[MSB:0];
        f.carry = diff[DATA_WIDTH];
        f.ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_ADDS: begin
        f.carry = sum[DATA_WIDTH];
        f.sat   = sum[DATA_WIDTH];
        res     = sum[DATA_WIDTH] ? '1 : sum[MSB:0];
      end
      OP_SUBS: begin
        f.carry = diff[DATA_WIDTH];
        f.sat   = diff[DATA_WIDTH];
        res     = diff[DATA_WIDTH] ? '0 : diff[MSB:0];
      end
      default: f.err = 1'b1;
    endcase
    // An illegal opcode reports only err, so zero is suppressed for it.
    f.zero = !f.err && (res == '0);
    return {f, res};
  endfunction

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; A and B transfer together, and ready never looks at out_ready_i.
  assign full         = (skid_state == SKID_TWO);
  assign in_a_ready_o = in_b_valid_i & ~full & ~rst_i;
  assign in_b_ready_o = in_a_valid_i & ~full & ~rst_i;
  assign fire         = in_a_valid_i & in_a_ready_o;
  assign alu_payload  = alu_eval(alu_op_e'(in_a_op_i), in_a_i, in_b_i);

  stream_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_data   (alu_payload),
    .in_valid  (fire),
    .out_data  (out_payload),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .state     (skid_state)
  );

  assign out_flags_o = out_payload[PW-1:DATA_WIDTH];
  assign out_o       = out_payload[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_alu_stream.sv
// Randomized and directed bench for alu_stream against an arithmetic reference model.
module tb_alu_stream;

  localparam int W  = 8;
  localparam int PW = W + 5;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_a;
  logic [2:0]   in_a_op;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] in_b;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] out_data;
  logic [4:0]   out_flags;
  logic         out_valid;
  logic         out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int fire_cnt = 0;
  int pop_cnt  = 0;
  bit a_acc = 0;
  bit b_acc = 0;

  logic [PW-1:0] exp_q[$];

  alu_stream #(.DATA_WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_a_i       (in_a),
    .in_a_op_i    (in_a_op),
    .in_a_valid_i (a_valid),
    .in_a_ready_o (a_ready),
    .in_b_i       (in_b),
    .in_b_valid_i (b_valid),
    .in_b_ready_o (b_ready),
    .out_o        (out_data),
    .out_flags_o  (out_flags),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: flags {err,sat,zero,ovf,carry} above the W-bit result.
  function automatic logic [PW-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int ua, ub, sa, sb, r, s, umax, smax, smin;
    bit c, o, st, e, z;
    logic [W-1:0] res;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    umax = (1 << W) - 1; smax = (1 << (W - 1)) - 1; smin = -(1 << (W - 1));
    c = 0; o = 0; st = 0; e = 0; r = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > umax); s = sa + sb; o = (s > smax) || (s < smin); end
      3'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; o = (s > smax) || (s < smin); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua + ub; if (r > umax) begin r = umax; st = 1; c = 1; end end
      3'd6: begin if (ua < ub) begin r = 0; st = 1; c = 1; end else r = ua - ub; end
      default: e = 1;
    endcase
    r = r & umax;
    z = !e && (r == 0);
    res = r[W-1:0];
    return {e, st, z, o, c, res};
  endfunction

  // scoreboard: occupancy model = accepted results not yet popped (at most 2)
  always @(negedge clk) begin
    logic [PW-1:0] exp;
    bit full_m;
    a_acc = 0;
    b_acc = 0;
    if (rst) begin
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      exp_q.delete();
    end else begin
      full_m = (exp_q.size() >= 2);
      check("a_ready", 32'(a_ready), 32'(b_valid && !full_m));
      check("b_ready", 32'(b_ready), 32'(a_valid && !full_m));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      check("join", 32'(a_acc), 32'(b_acc));
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("pop_empty", 32'(out_valid), 32'd0);
        else begin
          exp = exp_q.pop_front();
          check("result", 32'({out_flags, out_data}), 32'(exp));
        end
      end
      if (a_acc && b_acc) begin
        fire_cnt++;
        exp_q.push_back(ref_alu(in_a_op, in_a, in_b));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_valid = 0; b_valid = 0; out_ready = 1;
    end
  endtask

  task automatic directed(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic [4:0] ef, input string tag);
    @(posedge clk); #1;
    in_a = a; in_a_op = op; in_b = b; a_valid = 1; b_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, 32'(out_data), 32'(er));
    check({tag, "_flags"}, 32'(out_flags), 32'(ef));
  endtask

  task automatic step(input bit av, input bit bv, input bit ordy);
    @(posedge clk); #1;
    if (a_acc) begin in_a = W'($urandom); in_a_op = 3'($urandom_range(0, 7)); end
    if (b_acc) in_b = W'($urandom);
    a_valid = av; b_valid = bv; out_ready = ordy;
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] corners[4];
    corners[0] = '0; corners[1] = '1;
    corners[2] = {1'b0, {(W-1){1'b1}}}; corners[3] = {1'b1, {(W-1){1'b0}}};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    int f0, p0;
    rst = 1; a_valid = 0; b_valid = 0; out_ready = 0;
    in_a = '0; in_b = '0; in_a_op = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", 32'(out_data), 32'd0);
    check("reset_flags", 32'(out_flags), 32'd0);

    directed(3'd0, 8'hF0, 8'h20, 8'h10, 5'b00001, "add_carry");
    directed(3'd5, 8'hF0, 8'h20, 8'hFF, 5'b01001, "adds_sat");
    directed(3'd6, 8'h05, 8'h07, 8'h00, 5'b01101, "subs_floor");
    directed(3'd1, 8'h05, 8'h07, 8'hFE, 5'b00001, "sub_borrow");
    directed(3'd0, 8'h7F, 8'h01, 8'h80, 5'b00010, "add_ovf");
    directed(3'd7, 8'h12, 8'h34, 8'h00, 5'b10000, "illegal");
    idle(2);

    // join: A alone for three cycles, then B arrives
    @(posedge clk); #1;
    in_a = 8'h11; in_a_op = 3'd2; in_b = 8'h13; a_valid = 1; b_valid = 0; out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      check("join_wait_a_ready", 32'(a_ready), 32'd0);
      check("join_wait_out", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    b_valid = 1;
    p0 = pop_cnt;
    @(negedge clk);
    check("join_a_ready", 32'(a_ready), 32'd1);
    check("join_b_ready", 32'(b_ready), 32'd1);
    idle(4);
    check("join_one_result", 32'(pop_cnt - p0), 32'd1);

    // backpressure: two results fill the buffer, then readies drop
    f0 = fire_cnt;
    @(posedge clk); #1;
    in_a = rand_operand(); in_b = rand_operand(); in_a_op = 3'($urandom_range(0, 7));
    a_valid = 1; b_valid = 1; out_ready = 0;
    repeat (3) step(1, 1, 0);
    @(negedge clk);
    check("bp_fires", 32'(fire_cnt - f0), 32'd2);
    check("bp_ready_low", 32'(a_ready), 32'd0);
    p0 = pop_cnt;
    step(0, 0, 1);
    @(negedge clk);
    check("bp_first_pop", 32'(out_valid), 32'd1);
    step(0, 0, 1);
    @(negedge clk);
    check("bp_second_pop", 32'(out_valid), 32'd1);
    idle(2);
    check("bp_pops", 32'(pop_cnt - p0), 32'd2);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // randomized traffic with held beats and random backpressure
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (!a_valid || a_acc) begin
        a_valid = ($urandom_range(0, 3) != 0);
        in_a = rand_operand(); in_a_op = 3'($urandom_range(0, 7));
      end
      if (!b_valid || b_acc) begin
        b_valid = ($urandom_range(0, 3) != 0);
        in_b = rand_operand();
      end
      out_ready = (i % 100 > 70) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    idle(5);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // reset with the skid full, then the next fired beat comes out first
    @(posedge clk); #1;
    in_a = rand_operand(); in_b = rand_operand(); in_a_op = 3'd0;
    a_valid = 1; b_valid = 1; out_ready = 0;
    repeat (3) step(1, 1, 0);
    @(negedge clk);
    check("rst_pre_full", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    in_a = 8'h3C; in_b = 8'h0F; in_a_op = 3'd4; a_valid = 1; b_valid = 1; out_ready = 1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    check("rst_next_res", 32'(out_data), 32'h33);
    check("rst_next_flags", 32'(out_flags), 32'd0);
    idle(3);
    check("rst_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
